// File: rtl/fp_sqrt_iterative.sv
// fp_sqrt_iterative: multi-cycle square root for IEEE-style binary formats
// {sign, EXP_W exponent, MANT_W fraction}. It uses a restoring digit recurrence
// that resolves ROOT_BITS_PER_CYCLE root bits per cycle, and it rounds to
// nearest-even. Operands arrive and results leave over valid/ready handshakes.
// Optional build macro FP_SQRT_SUBNORM_EN: subnormal operands are normalised
// with a leading-zero count. Without it they are flushed to a signed zero.
module fp_sqrt_iterative #(
  parameter int EXP_W               = 5,
  parameter int MANT_W              = 10,
  parameter int ROOT_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] out_data,
  output logic                  out_invalid,
  output logic                  out_inexact,
  output logic                  busy
);

  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int RW    = MANT_W + 2;          // root: hidden, fraction, guard
  localparam int REM_W = RW + 2;              // partial remainder never exceeds 2*root
  localparam int RAD_W = 2 * RW;              // radicand bits consumed two per step
  localparam int R     = ROOT_BITS_PER_CYCLE;
  localparam int N     = (RW + R - 1) / R;    // ITER cycles
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int E_W   = EXP_W + 2;           // signed exponent path
  localparam logic signed [E_W-1:0] BIAS = E_W'((1 << (EXP_W - 1)) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [W-1:0]           r_op;
  logic [RAD_W-1:0]       r_rad;
  logic [REM_W-1:0]       r_rem;
  logic [RW-1:0]          r_root;
  logic [CNT_W-1:0]       r_cnt;
  logic signed [E_W-1:0]  r_res_exp;
  logic                   r_special;
  logic [W-1:0]           r_spec_data;
  logic                   r_spec_invalid;
  logic [W-1:0]           r_out_data;
  logic                   r_out_invalid;
  logic                   r_out_inexact;

  // ---------------------------------------------------------------------------
  // Operand unpacking and classification (evaluated while in PREP)
  // ---------------------------------------------------------------------------
  logic                   w_sign;
  logic [EXP_W-1:0]       w_exp;
  logic [MANT_W-1:0]      w_frac;
  logic                   w_exp_ones;
  logic                   w_is_nan;
  logic                   w_is_inf;
  logic                   w_is_zero;
  logic [MANT_W-1:0]      w_norm_frac;
  logic signed [E_W-1:0]  w_e;
  logic [RW-1:0]          w_sig_init;

  assign {w_sign, w_exp, w_frac} = r_op;
  assign w_exp_ones = &w_exp;
  assign w_is_nan   = w_exp_ones & (|w_frac);
  assign w_is_inf   = w_exp_ones & ~(|w_frac);

`ifdef FP_SQRT_SUBNORM_EN
  localparam int CLZ_W = $clog2(MANT_W + 1);
  logic [CLZ_W-1:0] w_clz;
  logic             w_clz_hit;
  logic [CLZ_W-1:0] w_shamt;
  logic             w_is_sub;

  // Leading-zero count of the fraction, which gives the normalising shift for subnormals
  always_comb begin
    w_clz     = '0;
    w_clz_hit = 1'b0;
    for (int k = MANT_W - 1; k >= 0; k--) begin
      if (!w_clz_hit) begin
        if (w_frac[k]) begin
          w_clz_hit = 1'b1;
        end else begin
          w_clz = w_clz + CLZ_W'(1);
        end
      end
    end
  end

  // Shift the leading one into the hidden position. The exponent drops by the same amount.
  assign w_shamt     = w_clz + CLZ_W'(1);
  assign w_is_sub    = (w_exp == '0) & (|w_frac);
  assign w_is_zero   = (w_exp == '0) & ~(|w_frac);
  assign w_norm_frac = w_is_sub ? (w_frac << w_shamt) : w_frac;
  assign w_e         = w_is_sub ? ($signed(E_W'(1)) - BIAS - $signed(E_W'(w_shamt)))
                                : ($signed(E_W'(w_exp)) - BIAS);
`else
  // Denormals-are-zero: any zero exponent field is treated as a signed zero
  assign w_is_zero   = (w_exp == '0);
  assign w_norm_frac = w_frac;
  assign w_e         = $signed(E_W'(w_exp)) - BIAS;
`endif

  // For an odd exponent, double the significand so the halved exponent stays exact.
  // For odd e, (e-1)>>>1 equals e>>>1, so the result exponent needs no separate adjust.
  assign w_sig_init = w_e[0] ? {1'b1, w_norm_frac, 1'b0} : {2'b01, w_norm_frac};

  logic         w_spec;
  logic [W-1:0] w_spec_data;
  logic         w_spec_invalid;

  // Resolve NaN, zero, negative and infinity operands straight to their final result
  always_comb begin
    w_spec         = 1'b0;
    w_spec_data    = '0;
    w_spec_invalid = 1'b0;
    if (w_is_nan) begin
      w_spec         = 1'b1;
      w_spec_data    = {w_sign, {EXP_W{1'b1}}, 1'b1, w_frac[MANT_W-2:0]};
      w_spec_invalid = ~w_frac[MANT_W-1];
    end else if (w_is_zero) begin
      w_spec         = 1'b1;
      w_spec_data    = {w_sign, {(EXP_W + MANT_W){1'b0}}};
    end else if (w_sign) begin
      w_spec         = 1'b1;
      w_spec_data    = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MANT_W - 1){1'b0}}};
      w_spec_invalid = 1'b1;
    end else if (w_is_inf) begin
      w_spec         = 1'b1;
      w_spec_data    = {1'b0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring recurrence: R chained steps per cycle. Steps past the last root
  // bit pass their inputs through unchanged, which covers R not dividing RW.
  // ---------------------------------------------------------------------------
  logic [REM_W-1:0] w_rem_chain  [0:R];
  logic [RW-1:0]    w_root_chain [0:R];
  logic [RAD_W-1:0] w_rad_chain  [0:R];

  assign w_rem_chain[0]  = r_rem;
  assign w_root_chain[0] = r_root;
  assign w_rad_chain[0]  = r_rad;

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_step
      logic [REM_W-1:0] w_shifted;
      logic [REM_W-1:0] w_trial;
      logic             w_ge;
      logic             w_active;

      assign w_active  = ((int'(r_cnt) * R) + gi) < RW;
      assign w_shifted = {w_rem_chain[gi][REM_W-3:0], w_rad_chain[gi][RAD_W-1 -: 2]};
      assign w_trial   = {w_root_chain[gi], 2'b01};
      assign w_ge      = (w_shifted >= w_trial);

      assign w_rem_chain[gi+1]  = !w_active ? w_rem_chain[gi]
                                : (w_ge ? (w_shifted - w_trial) : w_shifted);
      assign w_root_chain[gi+1] = !w_active ? w_root_chain[gi]
                                : {w_root_chain[gi][RW-2:0], w_ge};
      assign w_rad_chain[gi+1]  = !w_active ? w_rad_chain[gi]
                                : {w_rad_chain[gi][RAD_W-3:0], 2'b00};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round to nearest-even and pack
  // ---------------------------------------------------------------------------
  logic              w_guard;
  logic              w_lsb;
  logic              w_sticky;
  logic              w_round_up;
  logic              w_carry;
  logic [MANT_W-1:0] w_frac_rnd;
  logic [EXP_W-1:0]  w_exp_packed;
  logic [W-1:0]      w_num_data;

  assign w_guard    = r_root[0];
  assign w_lsb      = r_root[1];
  assign w_sticky   = |r_rem;
  assign w_round_up = w_guard & (w_sticky | w_lsb);
  // A carry out only happens when the whole significand is ones. The fraction then wraps to zero.
  assign w_carry      = w_round_up & (&r_root[RW-1:1]);
  assign w_frac_rnd   = r_root[MANT_W:1] + MANT_W'(w_round_up);
  assign w_exp_packed = EXP_W'(r_res_exp + BIAS + $signed(E_W'(w_carry)));
  assign w_num_data   = {1'b0, w_exp_packed, w_frac_rnd};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          w_state_next = S_PREP;
        end
      end
      S_PREP: begin
        busy         = 1'b1;
        w_state_next = w_spec ? S_ROUND : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(N - 1)) begin
          w_state_next = S_ROUND;
        end
      end
      S_ROUND: begin
        busy         = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = ~rst;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // Capture the operand, unpack it, iterate, then round into the held output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op           <= '0;
      r_rad          <= '0;
      r_rem          <= '0;
      r_root         <= '0;
      r_cnt          <= '0;
      r_res_exp      <= '0;
      r_special      <= 1'b0;
      r_spec_data    <= '0;
      r_spec_invalid <= 1'b0;
      r_out_data     <= '0;
      r_out_invalid  <= 1'b0;
      r_out_inexact  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op <= in_data;
          end
        end
        S_PREP: begin
          r_special      <= w_spec;
          r_spec_data    <= w_spec_data;
          r_spec_invalid <= w_spec_invalid;
          r_rad          <= {w_sig_init, {RW{1'b0}}};
          r_rem          <= '0;
          r_root         <= '0;
          r_cnt          <= '0;
          r_res_exp      <= w_e >>> 1;
        end
        S_ITER: begin
          r_rem  <= w_rem_chain[R];
          r_root <= w_root_chain[R];
          r_rad  <= w_rad_chain[R];
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        S_ROUND: begin
          if (r_special) begin
            r_out_data    <= r_spec_data;
            r_out_invalid <= r_spec_invalid;
            r_out_inexact <= 1'b0;
          end else begin
            r_out_data    <= w_num_data;
            r_out_invalid <= 1'b0;
            r_out_inexact <= w_guard | w_sticky;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign out_invalid = r_out_invalid;
  assign out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fp_sqrt_iterative.sv
// Testbench for fp_sqrt_iterative (fp16 format). Three instances with 1, 2 and 4
// root bits per cycle. A scoreboard queue receives the expected results as operands
// are accepted. The queue is checked as results emerge.
module tb_fp_sqrt_iterative;

  typedef struct {
    logic [15:0] din;
    logic [15:0] data;
    logic        inv;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      in_valid = '0;
  logic [2:0]      in_ready;
  logic [2:0][15:0] in_data = '0;
  logic [2:0]      out_valid;
  logic [2:0]      out_ready = '0;
  logic [2:0][15:0] out_data;
  logic [2:0]      out_invalid;
  logic [2:0]      out_inexact;
  logic [2:0]      busy;

  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  exp_t sb[$];

  localparam logic [15:0] NUM_IN  [4] = '{16'h4400, 16'h4000, 16'h3C00, 16'h4880};
  localparam logic [15:0] NUM_OUT [4] = '{16'h4000, 16'h3DA8, 16'h3C00, 16'h4200};
  localparam logic [3:0]  NUM_INX = 4'b0010;

  localparam logic [15:0] SP_IN  [7] = '{16'hC000, 16'h7C00, 16'h8000, 16'h7D00,
                                         16'hFC00, 16'h7E01, 16'h0000};
  localparam logic [15:0] SP_OUT [7] = '{16'hFE00, 16'h7C00, 16'h8000, 16'h7F00,
                                         16'hFE00, 16'h7E01, 16'h0000};
  localparam logic [6:0]  SP_INV = 7'b0011001;

  localparam logic [15:0] SUB_IN [3] = '{16'h0001, 16'h0200, 16'h8001};
`ifdef FP_SQRT_SUBNORM_EN
  localparam logic [15:0] SUB_OUT [3] = '{16'h0C00, 16'h1DA8, 16'hFE00};
  localparam logic [2:0]  SUB_INV = 3'b100;
  localparam logic [2:0]  SUB_INX = 3'b010;
  localparam int          SUB_LAT [3] = '{14, 14, 2};
`else
  localparam logic [15:0] SUB_OUT [3] = '{16'h0000, 16'h0000, 16'h8000};
  localparam logic [2:0]  SUB_INV = 3'b000;
  localparam logic [2:0]  SUB_INX = 3'b000;
  localparam int          SUB_LAT [3] = '{2, 2, 2};
`endif

  fp_sqrt_iterative #(.EXP_W(5), .MANT_W(10), .ROOT_BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_invalid(out_invalid[0]), .out_inexact(out_inexact[0]), .busy(busy[0])
  );

  fp_sqrt_iterative #(.EXP_W(5), .MANT_W(10), .ROOT_BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_invalid(out_invalid[1]), .out_inexact(out_inexact[1]), .busy(busy[1])
  );

  fp_sqrt_iterative #(.EXP_W(5), .MANT_W(10), .ROOT_BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_invalid(out_invalid[2]), .out_inexact(out_inexact[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference square root for positive normal fp16 values.
  // The integer root comes from a binary search, and the rounding is to nearest-even.
  function automatic exp_t model(input logic [15:0] x);
    exp_t r;
    int sig, e, rad, lo, hi, mid, root, rem, sigr, ex;
    logic g, l, s, up;
    sig = 1024 + int'(x[9:0]);
    e   = int'(x[14:10]) - 15;
    if (e % 2 != 0) begin
      sig = sig * 2;
      e   = e - 1;
    end
    rad = sig << 12;
    lo = 0;
    hi = 4095;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= rad) lo = mid;
      else hi = mid - 1;
    end
    root = lo;
    rem  = rad - root * root;
    g  = root[0];
    l  = root[1];
    s  = (rem != 0);
    up = g & (s | l);
    sigr = (root >> 1) + int'(up);
    ex   = e / 2 + 15;
    if (sigr >= 2048) begin
      ex   = ex + 1;
      sigr = 1024;
    end
    r.din  = x;
    r.data = {1'b0, ex[4:0], sigr[9:0]};
    r.inv  = 1'b0;
    r.inx  = g | s;
    r.lat  = 14;
    r.acc  = 0;
    return r;
  endfunction

  function automatic exp_t mk(input logic [15:0] din, input logic [15:0] data,
                              input logic inv, input logic inx, input int lat);
    exp_t r;
    r.din  = din;
    r.data = data;
    r.inv  = inv;
    r.inx  = inx;
    r.lat  = lat;
    r.acc  = 0;
    return r;
  endfunction

  // Present an operand until it is accepted, then enqueue its expected result
  task automatic send(input int d, input logic [15:0] x, input exp_t e);
    logic acc;
    acc = 1'b0;
    in_data[d]  = x;
    in_valid[d] = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      acc = in_ready[d];
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    if (!acc) begin
      n_total++;
      n_bad++;
      $display("FAIL send_accept dut%0d in=%h: in_ready never seen, required 1", d, x);
    end else begin
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  // Wait for a result, report it, pop its expectation and complete the handshake
  task automatic recv(input int d, output logic [15:0] od, output logic oi, output logic ox,
                      output int lat, output logic to, output exp_t e);
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (out_valid[d]) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    od = out_data[d];
    oi = out_invalid[d];
    ox = out_inexact[d];
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e = mk('x, 'x, 1'bx, 1'bx, -1);
      e.acc = cyc;
    end
    lat = cyc - e.acc;
    $display("txn dut%0d in=%h out=%h inv=%b inx=%b lat=%0d", d, e.din, od, oi, ox, lat);
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 3'b000 || busy !== 3'b000 || out_data !== '0 ||
        out_invalid !== 3'b000 || out_inexact !== 3'b000 || in_ready !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_state got valid=%b busy=%b data=%h inv=%b inx=%b rdy=%b, required all zero",
               out_valid, busy, out_data, out_invalid, out_inexact, in_ready);
    end
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_release in_ready=%b required 111", in_ready);
    end
  endtask

  task automatic test_numeric();
    logic [15:0] od;
    logic oi, ox, to;
    int lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(0, NUM_IN[i], mk(NUM_IN[i], NUM_OUT[i], 1'b0, NUM_INX[i], 14));
      recv(0, od, oi, ox, lat, to, e);
      n_total++;
      if (to || od !== e.data || oi !== e.inv || ox !== e.inx || lat != e.lat) begin
        n_bad++;
        $display("FAIL numeric in=%h got %h inv=%b inx=%b lat=%0d to=%b, required %h inv=%b inx=%b lat=%0d",
                 e.din, od, oi, ox, lat, to, e.data, e.inv, e.inx, e.lat);
      end
    end
  endtask

  task automatic test_special();
    logic [15:0] od;
    logic oi, ox, to;
    int lat;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      send(0, SP_IN[i], mk(SP_IN[i], SP_OUT[i], SP_INV[i], 1'b0, 2));
      recv(0, od, oi, ox, lat, to, e);
      n_total++;
      if (to || od !== e.data || oi !== e.inv || ox !== e.inx || lat != e.lat) begin
        n_bad++;
        $display("FAIL special in=%h got %h inv=%b inx=%b lat=%0d to=%b, required %h inv=%b inx=%b lat=%0d",
                 e.din, od, oi, ox, lat, to, e.data, e.inv, e.inx, e.lat);
      end
    end
  endtask

  task automatic test_subnormal();
    logic [15:0] od;
    logic oi, ox, to;
    int lat;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(0, SUB_IN[i], mk(SUB_IN[i], SUB_OUT[i], SUB_INV[i], SUB_INX[i], SUB_LAT[i]));
      recv(0, od, oi, ox, lat, to, e);
      n_total++;
      if (to || od !== e.data || oi !== e.inv || ox !== e.inx || lat != e.lat) begin
        n_bad++;
        $display("FAIL subnormal in=%h got %h inv=%b inx=%b lat=%0d to=%b, required %h inv=%b inx=%b lat=%0d",
                 e.din, od, oi, ox, lat, to, e.data, e.inv, e.inx, e.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] od, snap_d;
    logic oi, ox, to, snap_i, snap_x;
    int lat;
    exp_t e;
    exp_t ea;
    send(0, 16'h4880, model(16'h4880));
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (out_valid[0]) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_total++;
    if (to) begin
      n_bad++;
      $display("FAIL bp_wait out_valid=0 after 100 cycles, required 1");
    end
    snap_d = out_data[0];
    snap_i = out_invalid[0];
    snap_x = out_inexact[0];
    in_data[0]  = 16'h4400;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_total++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== snap_d || out_invalid[0] !== snap_i ||
          out_inexact[0] !== snap_x || in_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d got valid=%b data=%h inv=%b inx=%b rdy=%b, required 1 %h %b %b 0",
                 i, out_valid[0], out_data[0], out_invalid[0], out_inexact[0], in_ready[0],
                 snap_d, snap_i, snap_x);
      end
    end
    ea = sb.pop_front();
    $display("txn dut0 in=%h out=%h inv=%b inx=%b held", ea.din, snap_d, snap_i, snap_x);
    n_total++;
    if (snap_d !== ea.data || snap_i !== ea.inv || snap_x !== ea.inx) begin
      n_bad++;
      $display("FAIL bp_result got %h inv=%b inx=%b, required %h inv=%b inx=%b",
               snap_d, snap_i, snap_x, ea.data, ea.inv, ea.inx);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    n_total++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_handshake got rdy=%b valid=%b, required rdy=1 valid=0", in_ready[0], out_valid[0]);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    n_total++;
    if (busy[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_b_accept got busy=%b rdy=%b, required busy=1 rdy=0", busy[0], in_ready[0]);
    end
    e = model(16'h4400);
    e.acc = cyc;
    sb.push_back(e);
    recv(0, od, oi, ox, lat, to, e);
    n_total++;
    if (to || od !== e.data || oi !== e.inv || ox !== e.inx || lat != e.lat) begin
      n_bad++;
      $display("FAIL bp_operand_b in=%h got %h inv=%b inx=%b lat=%0d to=%b, required %h inv=%b inx=%b lat=%0d",
               e.din, od, oi, ox, lat, to, e.data, e.inv, e.inx, e.lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] od;
    logic oi, ox, to, seen;
    int lat;
    exp_t e;
    send(0, 16'h4000, model(16'h4000));
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_abort got valid=%b busy=%b rdy=%b, required 0 0 0", out_valid[0], busy[0], in_ready[0]);
    end
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ready in_ready=%b required 1", in_ready[0]);
    end
    sb.delete();
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_result out_valid seen=%b, required 0", seen);
    end
    send(0, 16'h4400, mk(16'h4400, 16'h4000, 1'b0, 1'b0, 14));
    recv(0, od, oi, ox, lat, to, e);
    n_total++;
    if (to || od !== e.data || oi !== e.inv || ox !== e.inx || lat != e.lat) begin
      n_bad++;
      $display("FAIL rst_followup in=%h got %h inv=%b inx=%b lat=%0d to=%b, required %h inv=%b inx=%b lat=%0d",
               e.din, od, oi, ox, lat, to, e.data, e.inv, e.inx, e.lat);
    end
  endtask

  task automatic test_root_bits();
    logic [15:0] od, x;
    logic oi, ox, to;
    int lat;
    exp_t e, m;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) x = 16'h4000;
      else x = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
      for (int d = 0; d < 3; d++) begin
        if (i == 0) m = mk(16'h4000, 16'h3DA8, 1'b0, 1'b1, 14);
        else m = model(x);
        m.lat = (d == 0) ? 14 : ((d == 1) ? 8 : 5);
        send(d, x, m);
        recv(d, od, oi, ox, lat, to, e);
        n_total++;
        if (to || od !== e.data || oi !== e.inv || ox !== e.inx || lat != e.lat) begin
          n_bad++;
          $display("FAIL root_bits dut%0d in=%h got %h inv=%b inx=%b lat=%0d to=%b, required %h inv=%b inx=%b lat=%0d",
                   d, e.din, od, oi, ox, lat, to, e.data, e.inv, e.inx, e.lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_numeric();
    test_special();
    test_subnormal();
    test_backpressure();
    test_reset_mid();
    test_root_bits();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
